// File: rtl/bp_be_dcache_wbuf_queue_if.sv
// rtl/bp_be_dcache_wbuf_queue_if.sv - Store write buffer bus bundle: enqueue, head/drain and load bypass signals
//
// Signal groups:
//   enqueue : v_i, ready_o, paddr_i, data_i, mask_i, way_id_i
//   head    : v_o, yumi_i, paddr_o, data_o, mask_o, way_id_o
//   bypass  : bypass_v_i, bypass_paddr_i, bypass_data_o, bypass_mask_o
//   status  : empty_o, full_o
// slave is the buffer side and master is the side that drives it.
interface bp_be_dcache_wbuf_queue_if #(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 64,
    parameter int ways_p        = 8
);
    localparam int mask_width_lp = data_width_p / 8;
    localparam int way_width_lp  = $clog2(ways_p);

    logic                     v_i;
    logic                     ready_o;
    logic [paddr_width_p-1:0] paddr_i;
    logic [data_width_p-1:0]  data_i;
    logic [mask_width_lp-1:0] mask_i;
    logic [way_width_lp-1:0]  way_id_i;

    logic                     v_o;
    logic                     yumi_i;
    logic [paddr_width_p-1:0] paddr_o;
    logic [data_width_p-1:0]  data_o;
    logic [mask_width_lp-1:0] mask_o;
    logic [way_width_lp-1:0]  way_id_o;

    logic                     bypass_v_i;
    logic [paddr_width_p-1:0] bypass_paddr_i;
    logic [data_width_p-1:0]  bypass_data_o;
    logic [mask_width_lp-1:0] bypass_mask_o;

    logic                     empty_o;
    logic                     full_o;

    modport slave (
        input  v_i, paddr_i, data_i, mask_i, way_id_i,
        input  yumi_i, bypass_v_i, bypass_paddr_i,
        output ready_o, v_o, paddr_o, data_o, mask_o, way_id_o,
        output bypass_data_o, bypass_mask_o, empty_o, full_o
    );

    modport master (
        output v_i, paddr_i, data_i, mask_i, way_id_i,
        output yumi_i, bypass_v_i, bypass_paddr_i,
        input  ready_o, v_o, paddr_o, data_o, mask_o, way_id_o,
        input  bypass_data_o, bypass_mask_o, empty_o, full_o
    );
endinterface

// File: rtl/bp_be_dcache_wbuf_queue.sv
// rtl/bp_be_dcache_wbuf_queue.sv - Dcache store write buffer: in-order FIFO drain plus byte-granular load bypass
//
// Ports:
//   clk_i   : clock
//   reset_i : synchronous active-high reset
//   bus     : slave side of bp_be_dcache_wbuf_queue_if (enqueue, head/drain, bypass, status)
module bp_be_dcache_wbuf_queue #(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 64,
    parameter int ways_p        = 8,
    parameter int els_p         = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_be_dcache_wbuf_queue_if.slave bus
);
    localparam int mask_width_lp = data_width_p / 8;
    localparam int way_width_lp  = $clog2(ways_p);
    localparam int ptr_width_lp  = $clog2(els_p);
    localparam int cnt_width_lp  = $clog2(els_p + 1);

    logic [paddr_width_p-1:0] paddr_r [els_p];
    logic [data_width_p-1:0]  data_r  [els_p];
    logic [mask_width_lp-1:0] mask_r  [els_p];
    logic [way_width_lp-1:0]  way_r   [els_p];

    logic [ptr_width_lp-1:0]  rptr_r;
    logic [ptr_width_lp-1:0]  wptr_r;
    logic [cnt_width_lp-1:0]  count_r;

    logic full;
    logic enq;
    logic deq;

    // ready depends only on count_r, so there is no path from yumi_i to ready_o.
    assign full = (count_r == cnt_width_lp'(els_p));
    assign enq  = bus.v_i & ~full;
    assign deq  = bus.yumi_i & (count_r != '0);

    assign bus.ready_o  = ~full;
    assign bus.full_o   = full;
    assign bus.empty_o  = (count_r == '0);
    assign bus.v_o      = (count_r != '0);
    assign bus.paddr_o  = paddr_r[rptr_r];
    assign bus.data_o   = data_r[rptr_r];
    assign bus.mask_o   = mask_r[rptr_r];
    assign bus.way_id_o = way_r[rptr_r];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r  <= '0;
            wptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + ptr_width_lp'(1);
            if (deq) rptr_r <= rptr_r + ptr_width_lp'(1);
            case ({enq, deq})
                2'b10:   count_r <= count_r + cnt_width_lp'(1);
                2'b01:   count_r <= count_r - cnt_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is never cleared; validity comes from count_r alone.
    always_ff @(posedge clk_i) begin
        if (!reset_i && enq) begin
            paddr_r[wptr_r] <= bus.paddr_i;
            data_r[wptr_r]  <= bus.data_i;
            mask_r[wptr_r]  <= bus.mask_i;
            way_r[wptr_r]   <= bus.way_id_i;
        end
    end

    // Walk entries oldest (k=0 at rptr) to youngest so later writes to a byte win.
    // Only registered storage is consulted: a same-cycle enqueue is invisible and
    // a head being consumed this cycle is still visible.
    logic [ptr_width_lp-1:0]  byp_idx;
    logic [data_width_p-1:0]  byp_data;
    logic [mask_width_lp-1:0] byp_mask;

    always_comb begin
        byp_idx  = '0;
        byp_data = '0;
        byp_mask = '0;
        if (bus.bypass_v_i) begin
            for (int k = 0; k < els_p; k++) begin
                byp_idx = rptr_r + ptr_width_lp'(k);
                if ((cnt_width_lp'(k) < count_r) &&
                    (paddr_r[byp_idx][paddr_width_p-1:3] == bus.bypass_paddr_i[paddr_width_p-1:3])) begin
                    for (int b = 0; b < mask_width_lp; b++) begin
                        if (mask_r[byp_idx][b]) begin
                            byp_data[8*b +: 8] = data_r[byp_idx][8*b +: 8];
                            byp_mask[b]        = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.bypass_data_o = byp_data;
    assign bus.bypass_mask_o = byp_mask;

    // Byte offset within the dword plays no part in matching.
    logic unused_bypass_low;
    assign unused_bypass_low = ^bus.bypass_paddr_i[2:0];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(bus.v_i && full)) else $error("wbuf: enqueue while full");
            assert (!(bus.yumi_i && (count_r == '0))) else $error("wbuf: yumi while empty");
        end
    end
endmodule

// File: tb/tb_bp_be_dcache_wbuf_queue.sv
// tb/tb_bp_be_dcache_wbuf_queue.sv - Directed self-checking bench for bp_be_dcache_wbuf_queue
module tb_bp_be_dcache_wbuf_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [39:0] exp_q [$];
    logic [39:0] head_exp;

    bp_be_dcache_wbuf_queue_if #(.paddr_width_p(40), .data_width_p(64), .ways_p(8)) bus ();

    bp_be_dcache_wbuf_queue #(.paddr_width_p(40), .data_width_p(64), .ways_p(8), .els_p(2)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_enq(input logic v, input logic [39:0] a, input logic [63:0] d,
                           input logic [7:0] m, input logic [2:0] w);
        bus.v_i      = v;
        bus.paddr_i  = a;
        bus.data_i   = d;
        bus.mask_i   = m;
        bus.way_id_i = w;
    endtask

    initial begin
        set_enq(1'b0, '0, '0, '0, '0);
        bus.yumi_i         = 1'b0;
        bus.bypass_v_i     = 1'b0;
        bus.bypass_paddr_i = '0;
        tick();
        tick();
        reset = 1'b0;
        settle();

        // Reset / idle state
        check("rst_v_o",   {63'd0, bus.v_o},     64'd0);
        check("rst_empty", {63'd0, bus.empty_o}, 64'd1);
        check("rst_ready", {63'd0, bus.ready_o}, 64'd1);
        check("rst_full",  {63'd0, bus.full_o},  64'd0);
        bus.bypass_v_i = 1'b1;
        bus.bypass_paddr_i = 40'h1000;
        settle();
        check("rst_byp_mask", {56'd0, bus.bypass_mask_o}, 64'd0);
        bus.bypass_v_i = 1'b0;

        // Single enqueue, no fall-through, then drain
        set_enq(1'b1, 40'h1000, 64'h1122334455667788, 8'hFF, 3'd3);
        settle();
        check("nofall_v_o", {63'd0, bus.v_o}, 64'd0);
        tick();
        set_enq(1'b0, '0, '0, '0, '0);
        settle();
        check("one_v_o",   {63'd0, bus.v_o}, 64'd1);
        check("one_paddr", {24'd0, bus.paddr_o}, 64'h1000);
        check("one_way",   {61'd0, bus.way_id_o}, 64'd3);
        check("one_data",  bus.data_o, 64'h1122334455667788);
        check("one_mask",  {56'd0, bus.mask_o}, 64'hFF);
        check("one_empty", {63'd0, bus.empty_o}, 64'd0);
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i = 1'b0;
        settle();
        check("drain_empty", {63'd0, bus.empty_o}, 64'd1);
        check("drain_v_o",   {63'd0, bus.v_o}, 64'd0);

        // Fill to full
        set_enq(1'b1, 40'h10, 64'h0101010101010101, 8'hFF, 3'd1);
        tick();
        set_enq(1'b1, 40'h18, 64'h0202020202020202, 8'hFF, 3'd2);
        tick();
        set_enq(1'b0, '0, '0, '0, '0);
        settle();
        check("full_full",  {63'd0, bus.full_o}, 64'd1);
        check("full_ready", {63'd0, bus.ready_o}, 64'd0);
        tick();
        check("full_hold",  {63'd0, bus.full_o}, 64'd1);
        check("full_head",  {24'd0, bus.paddr_o}, 64'h10);
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i = 1'b0;
        settle();
        check("deq_ready", {63'd0, bus.ready_o}, 64'd1);
        check("deq_full",  {63'd0, bus.full_o}, 64'd0);
        check("deq_head",  {24'd0, bus.paddr_o}, 64'h18);
        check("deq_data",  bus.data_o, 64'h0202020202020202);

        // Refill, then streaming enqueue+dequeue across pointer wraps
        exp_q.push_back(40'h18);
        set_enq(1'b1, 40'h20, 64'h0303030303030303, 8'hFF, 3'd4);
        tick();
        exp_q.push_back(40'h20);
        set_enq(1'b0, '0, '0, '0, '0);
        settle();
        check("refill_full", {63'd0, bus.full_o}, 64'd1);
        head_exp = exp_q.pop_front();
        check("refill_head", {24'd0, bus.paddr_o}, {24'd0, head_exp});
        bus.yumi_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            set_enq(1'b1, 40'h100 + 40'(8 * i), {56'd0, 8'(i + 8'h40)}, 8'hFF, 3'(i));
            bus.yumi_i = 1'b1;
            settle();
            check("stream_ready", {63'd0, bus.ready_o}, 64'd1);
            head_exp = exp_q.pop_front();
            check("stream_head", {24'd0, bus.paddr_o}, {24'd0, head_exp});
            exp_q.push_back(40'h100 + 40'(8 * i));
            tick();
        end
        set_enq(1'b0, '0, '0, '0, '0);
        bus.yumi_i = 1'b1;
        settle();
        head_exp = exp_q.pop_front();
        check("stream_last", {24'd0, bus.paddr_o}, {24'd0, head_exp});
        check("stream_last_data", bus.data_o, 64'h49);
        tick();
        bus.yumi_i = 1'b0;
        settle();
        check("stream_empty", {63'd0, bus.empty_o}, 64'd1);

        // Bypass merge: A older, B younger to same dword
        set_enq(1'b1, 40'h2000, 64'h00000000AAAAAAAA, 8'h0F, 3'd0);
        tick();
        set_enq(1'b1, 40'h2004, 64'h000000000000BBBB, 8'h03, 3'd1);
        tick();
        set_enq(1'b0, '0, '0, '0, '0);
        bus.bypass_v_i = 1'b1;
        bus.bypass_paddr_i = 40'h2000;
        settle();
        check("byp_mask", {56'd0, bus.bypass_mask_o}, 64'h0F);
        check("byp_data", bus.bypass_data_o, 64'h00000000AAAABBBB);
        bus.bypass_paddr_i = 40'h2007;
        settle();
        check("byp_off_mask", {56'd0, bus.bypass_mask_o}, 64'h0F);
        bus.bypass_paddr_i = 40'h3000;
        settle();
        check("byp_miss_mask", {56'd0, bus.bypass_mask_o}, 64'h00);
        check("byp_miss_data", bus.bypass_data_o, 64'h0);
        bus.bypass_v_i = 1'b0;
        bus.bypass_paddr_i = 40'h2000;
        settle();
        check("byp_off_v_mask", {56'd0, bus.bypass_mask_o}, 64'h00);
        check("byp_off_v_data", bus.bypass_data_o, 64'h0);

        // Head being consumed still visible; after it leaves only B remains
        bus.bypass_v_i = 1'b1;
        bus.yumi_i = 1'b1;
        settle();
        check("byp_yumi_mask", {56'd0, bus.bypass_mask_o}, 64'h0F);
        tick();
        bus.yumi_i = 1'b0;
        settle();
        check("byp_b_mask", {56'd0, bus.bypass_mask_o}, 64'h03);
        check("byp_b_data", bus.bypass_data_o, 64'h000000000000BBBB);

        // Same-cycle enqueue is not seen by bypass
        set_enq(1'b1, 40'h2000, 64'hFFFFFFFF00000000, 8'hF0, 3'd2);
        settle();
        check("byp_newenq_mask", {56'd0, bus.bypass_mask_o}, 64'h03);
        tick();
        set_enq(1'b0, '0, '0, '0, '0);
        settle();
        check("byp_c_mask", {56'd0, bus.bypass_mask_o}, 64'hF3);
        check("byp_c_data", bus.bypass_data_o, 64'hFFFFFFFF0000BBBB);
        check("byp_c_full", {63'd0, bus.full_o}, 64'd1);

        // Reset while full with yumi asserted
        reset = 1'b1;
        bus.yumi_i = 1'b1;
        tick();
        reset = 1'b0;
        bus.yumi_i = 1'b0;
        settle();
        check("rst2_v_o",   {63'd0, bus.v_o}, 64'd0);
        check("rst2_empty", {63'd0, bus.empty_o}, 64'd1);
        check("rst2_ready", {63'd0, bus.ready_o}, 64'd1);
        check("rst2_byp",   {56'd0, bus.bypass_mask_o}, 64'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_be_dcache_wbuf_queue.md
Name: bp_be_dcache_wbuf_queue

Overview:
- Store write buffer between the dcache tag-verify (TV) stage and the data-memory write port.
- Committed store hits are enqueued with their way, byte mask and aligned data. They drain to data memory whenever the data-mem arbiter grants the port.
- Provides byte-granular load bypass so younger loads see buffered store data before it reaches data memory.

Parameters:
- paddr_width_p, 40, physical address width
- data_width_p, 64, store data width (one dword)
- ways_p, 8, dcache associativity; way_id width = $clog2(ways_p)
- els_p, 2, buffer depth (power of two, >= 2)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- v_i  in  1  enqueue valid from TV stage
- ready_o  out  1  space available; equals ~full, registered-state-derived, no combinational path from yumi_i
- paddr_i  in  paddr_width_p  store physical address (dword aligned in use)
- data_i  in  data_width_p  store data, already byte-lane aligned
- mask_i  in  data_width_p/8  byte write mask
- way_id_i  in  $clog2(ways_p)  hit way
- v_o  out  1  head entry valid toward data mem
- paddr_o / data_o / mask_o / way_id_o  out  as inputs  head entry fields
- yumi_i  in  1  data mem consumed head this cycle; only legal when v_o
- bypass_v_i  in  1  load lookup valid
- bypass_paddr_i  in  paddr_width_p  load address
- bypass_data_o  out  data_width_p  merged buffered bytes
- bypass_mask_o  out  data_width_p/8  bytes supplied by buffer
- empty_o  out  1  no entries held
- full_o  out  1  els_p entries held

Behaviour:
- Circular FIFO; read pointer, write pointer, count register of width $clog2(els_p+1).
- Reset (synchronous, wins over all inputs): pointers=0, count=0, v_o=0, empty_o=1, full_o=0, ready_o=1. Bypass_mask_o=0. Entry storage is not cleared.
- Enqueue: v_i & ready_o writes the entry at wptr; wptr increments mod els_p.
- v_i & ~ready_o is illegal; assertion fires and the entry is dropped with no state change.
- Dequeue: yumi_i advances rptr mod els_p. yumi_i with ~v_o is illegal (assertion); it is ignored.
- Simultaneous enqueue+dequeue: count unchanged, both pointers advance.
  - Legal when full only if ready_o was already 1, so a full buffer needs one dequeue cycle before it accepts again. No fall-through.
- Latency: an enqueued entry appears on v_o/head ports the cycle after enqueue at the earliest. Head outputs are combinational from storage[rptr].
- v_o = (count != 0). empty_o = (count == 0). full_o = (count == els_p).
- Bypass (combinational):
  - An entry matches when valid and paddr[paddr_width_p-1:3] == bypass_paddr_i[paddr_width_p-1:3].
  - Matching entries are merged oldest to youngest. For each byte b with mask[b]=1, the younger entry's byte overrides the older.
  - bypass_mask_o = OR of matching masks. Unmasked bytes of bypass_data_o = 0.
  - bypass_v_i=0 forces bypass_mask_o=0 and bypass_data_o=0.
  - Bypass reflects current storage only. A same-cycle v_i entry is not included; the head being yumi'd this cycle is still included.
- Ordering: entries drain strictly in enqueue order. Two stores to the same dword are never coalesced.

Test Plan:
- Reset then idle -> v_o=0, empty_o=1, ready_o=1, bypass_mask_o=0 for any address.
- Enqueue paddr=0x1000, data=0x1122334455667788, mask=0xFF, way=3; yumi_i held 0 -> next cycle v_o=1, paddr_o=0x1000, way_id_o=3, data_o matches. Assert yumi_i -> following cycle empty_o=1.
- Enqueue two entries (els_p=2), no yumi -> full_o=1, ready_o=0. Drive v_i=1 -> assertion, count stays 2. One yumi cycle -> ready_o=1 next cycle.
- Fill to full, then hold v_i & yumi_i every cycle for 10 cycles -> pointers wrap, drain order equals enqueue order, no drops.
- Buffer entries A: 0x2000 mask=0x0F data=0x..AAAAAAAA and B (younger): 0x2004 mask=0x03 data=0x..BBBB. Bypass 0x2000 -> mask=0x0F, low bytes = 0xAAAABBBB; upper 4 bytes = 0.
- Bypass 0x3000 with entries only at 0x2000 -> mask=0. Assert reset_i while full and yumi_i=1 -> next cycle count=0, v_o=0, ready_o=1.
